// File: rtl/common.sv
// Shared data-bus types and defaults used by the memory stage and its responders.
package common;

    localparam int DBUS_RESP_LATENCY = 2;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    // Read data is handed back shifted down to the addressed byte.
    function automatic logic [63:0] lane_shift(input logic [63:0] w, input logic [2:0] off);
        return w >> {off, 3'b000};
    endfunction

endpackage

// File: rtl/dbus_ram.sv
// Byte-strobed 64-bit single-port store: synchronous write, combinational read.
module dbus_ram #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    strb,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata
);

    logic [63:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 8; i++) begin
                if (strb[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dbus_responder.sv
// Data-bus slave model: accepts one request, waits LATENCY cycles, answers with a
// one-cycle addr_ok/data_ok pulse, and commits writes when leaving the response.
module dbus_responder
    import common::*;
#(
    parameter int LATENCY = DBUS_RESP_LATENCY,
    parameter int AW      = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] LAT = 4'(LATENCY);

    state_t      state;
    logic [3:0]  cnt;
    logic [63:0] l_addr;
    msize_t      l_size;
    logic [7:0]  l_strobe;
    logic [63:0] l_data;
    logic        l_wr;

    logic        accept;
    logic        go_resp;
    logic [63:0] cur_addr;
    logic        cur_wr;
    logic [63:0] rdata;
    logic [63:0] resp_data;
    logic        unused_bits;

    assign accept  = (state == IDLE) && dreq.valid;
    assign go_resp = (accept && (LATENCY == 0)) || ((state == WAIT) && (cnt == 4'd1));

    // In IDLE the store is looked up with the live request so LATENCY=0 can answer next cycle.
    assign cur_addr  = (state == IDLE) ? dreq.addr : l_addr;
    assign cur_wr    = (state == IDLE) ? (dreq.strobe != 8'h00) : l_wr;
    assign resp_data = cur_wr ? 64'h0 : lane_shift(rdata, cur_addr[2:0]);

    dbus_ram #(.AW(AW)) u_ram (
        .clk   (clk),
        .we    (state == RESP && l_wr),
        .addr  (cur_addr[AW+2:3]),
        .strb  (l_strobe),
        .wdata (l_data),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            l_addr   <= '0;
            l_size   <= MSIZE1;
            l_strobe <= '0;
            l_data   <= '0;
            l_wr     <= 1'b0;
            dresp    <= '0;
        end else begin
            dresp <= go_resp ? '{addr_ok: 1'b1, data_ok: 1'b1, data: resp_data} : '0;
            case (state)
                IDLE: begin
                    if (dreq.valid) begin
                        l_addr   <= dreq.addr;
                        l_size   <= dreq.size;
                        l_strobe <= dreq.strobe;
                        l_data   <= dreq.data;
                        l_wr     <= (dreq.strobe != 8'h00);
                        cnt      <= LAT;
                        state    <= (LATENCY == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Size is latched for visibility only; the requester applies masking.
    assign unused_bits = ^{l_size, cur_addr[63:AW+3]};

endmodule

// File: tb/tb_dbus_responder.sv
// Directed plus randomized checks of dbus_responder against a word-array reference.
module tb_dbus_responder;
    import common::*;

    logic       clk = 1'b0;
    logic       reset;
    dbus_req_t  rq2, rq0;
    dbus_resp_t rs2, rs0;

    int n_chk  = 0;
    int n_fail = 0;

    logic [63:0] mdl [8];

    dbus_responder #(.LATENCY(2), .AW(12)) dut2 (.clk(clk), .reset(reset), .dreq(rq2), .dresp(rs2));
    dbus_responder #(.LATENCY(0), .AW(12)) dut0 (.clk(clk), .reset(reset), .dreq(rq0), .dresp(rs0));

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request on the LATENCY=2 responder; valid drops after the accepting
    // edge and, when scramble is set, the other fields are overwritten with noise.
    task automatic do_req(input logic [63:0] a, input logic [7:0] s, input logic [63:0] d,
                          input msize_t sz, input logic scramble,
                          output logic [63:0] rd, output int lat);
        rq2.valid  = 1'b1;
        rq2.addr   = a;
        rq2.size   = sz;
        rq2.strobe = s;
        rq2.data   = d;
        lat = -1;
        rd  = 'x;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                rq2.valid = 1'b0;
                if (scramble) begin
                    rq2.addr   = {$urandom, $urandom};
                    rq2.data   = {$urandom, $urandom};
                    rq2.strobe = 8'($urandom);
                end
            end
            if (rs2.addr_ok || rs2.data_ok) begin
                chk("ok_pair", 66'(rs2.addr_ok), 66'(rs2.data_ok));
                lat = c;
                rd  = rs2.data;
                break;
            end
        end
        rq2.valid = 1'b0;
        @(negedge clk);
        chk("pulse_one", rs2, '0);
    endtask

    initial begin
        logic [63:0] rd, exp, prior, a, d;
        logic [7:0]  s;
        int          lat, w, off;

        reset = 1'b0;
        rq2 = '0;
        rq0 = '0;
        repeat (3) @(negedge clk);
        chk("reset_resp2", rs2, '0);
        chk("reset_resp0", rs0, '0);
        reset = 1'b1;
        @(negedge clk);

        // Basic write then byte-offset read
        do_req(64'h100, 8'hFF, 64'h1122334455667788, MSIZE8, 1'b0, rd, lat);
        chk("wr_latency", 66'(lat), 66'd3);
        chk("wr_data0", 66'(rd), 66'h0);
        do_req(64'h103, 8'h00, 64'h0, MSIZE1, 1'b0, rd, lat);
        chk("rd_latency", 66'(lat), 66'd3);
        chk("rd_shift", 66'(rd), 66'h0000001122334455);
        chk("rd_byte", 66'(rd[7:0]), 66'h55);

        // Partial strobe merge
        do_req(64'h108, 8'hFF, 64'hFFFFFFFFFFFFFFFF, MSIZE8, 1'b0, rd, lat);
        do_req(64'h108, 8'h0C, 64'h00000000ABCD0000, MSIZE2, 1'b0, rd, lat);
        do_req(64'h108, 8'h00, 64'h0, MSIZE8, 1'b0, rd, lat);
        chk("strobe_merge", 66'(rd), 66'hFFFFFFFFABCDFFFF);

        // Fields changing while in WAIT are ignored
        do_req(64'h110, 8'hFF, 64'h0123456789ABCDEF, MSIZE8, 1'b1, rd, lat);
        chk("scr_wr_lat", 66'(lat), 66'd3);
        chk("scr_wr_data", 66'(rd), 66'h0);
        do_req(64'h112, 8'h00, 64'h0, MSIZE8, 1'b1, rd, lat);
        chk("scr_rd", 66'(rd), 66'h0000_0123_4567_89AB);

        // High address bits alias onto the same word
        do_req(64'hFFFF_0000_0000_8100, 8'h00, 64'h0, MSIZE8, 1'b0, rd, lat);
        chk("alias", 66'(rd), 66'h1122334455667788);

        // Reset in WAIT and in RESP kills the write
        prior = 64'hCAFE_F00D_DEAD_BEEF;
        do_req(64'h200, 8'hFF, prior, MSIZE8, 1'b0, rd, lat);
        rq2 = '{valid: 1'b1, addr: 64'h200, size: MSIZE8, strobe: 8'hFF, data: 64'h5555_5555_5555_5555};
        @(negedge clk);
        rq2.valid = 1'b0;
        #2 reset = 1'b0;
        #1 chk("rst_wait", rs2, '0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        rq2 = '{valid: 1'b1, addr: 64'h200, size: MSIZE8, strobe: 8'hF0, data: 64'h6666_6666_6666_6666};
        @(negedge clk);
        rq2.valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_resp_pre", 66'(rs2.data_ok), 66'd1);
        #2 reset = 1'b0;
        #1 chk("rst_resp_async", rs2, '0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        do_req(64'h200, 8'h00, 64'h0, MSIZE8, 1'b0, rd, lat);
        chk("rst_idle_lat", 66'(lat), 66'd3);
        chk("rst_no_write", 66'(rd), 66'(prior));

        // LATENCY=0: back-to-back write then read
        rq0 = '{valid: 1'b1, addr: 64'h40, size: MSIZE8, strobe: 8'hFF, data: 64'hA5A5_0000_1234_5678};
        @(negedge clk);
        chk("l0_resp1", rs0, {1'b1, 1'b1, 64'h0});
        rq0.valid = 1'b0;
        @(negedge clk);
        chk("l0_idle2", rs0, '0);
        rq0 = '{valid: 1'b1, addr: 64'h44, size: MSIZE4, strobe: 8'h00, data: 64'h0};
        @(negedge clk);
        chk("l0_resp3", rs0, {1'b1, 1'b1, 64'h0000_0000_A5A5_0000});
        rq0.valid = 1'b0;
        @(negedge clk);
        chk("l0_idle4", rs0, '0);

        // Randomized traffic over eight words against the reference array
        for (int i = 0; i < 8; i++) begin
            mdl[i] = {$urandom, $urandom};
            do_req(64'h400 | (64'(i) << 3), 8'hFF, mdl[i], MSIZE8, 1'b0, rd, lat);
        end
        for (int t = 0; t < 60; t++) begin
            w   = int'($urandom_range(0, 7));
            off = int'($urandom_range(0, 7));
            a   = ({$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_8000) | 64'h400 | (64'(w) << 3) | 64'(off);
            d   = {$urandom, $urandom};
            s   = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
            do_req(a, s, d, MSIZE8, 1'($urandom), rd, lat);
            chk("rnd_lat", 66'(lat), 66'd3);
            if (s == 8'h00) begin
                exp = mdl[w] >> (off * 8);
            end else begin
                exp = 64'h0;
                for (int b = 0; b < 8; b++)
                    if (s[b]) mdl[w][8*b +: 8] = d[8*b +: 8];
            end
            chk("rnd_data", 66'(rd), 66'(exp));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
